// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared sizing constants for the register file and scoreboard.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

  localparam int          WIDTH    = 32;
  localparam int          DEPTH    = 32;
  localparam int          ADDR_W   = 5;
  localparam logic [4:0]  ZERO_REG = 5'd0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Brief    : Decode/writeback bus into the register file and scoreboard.
// Revision : 1.0
// ============================================================================
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int IF_WIDTH  = regfile_pkg::WIDTH,
  parameter int IF_ADDR_W = regfile_pkg::ADDR_W
);

  logic [IF_ADDR_W-1:0] ra_addr;
  logic [IF_ADDR_W-1:0] rb_addr;
  logic [IF_WIDTH-1:0]  ra_data;
  logic [IF_WIDTH-1:0]  rb_data;
  logic                 ra_busy;
  logic                 rb_busy;
  logic                 wr_en;
  logic [IF_ADDR_W-1:0] wr_addr;
  logic [IF_WIDTH-1:0]  wr_data;
  logic                 iss_en;
  logic [IF_ADDR_W-1:0] iss_addr;

  modport master (
    output ra_addr, rb_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  ra_data, rb_data, ra_busy, rb_busy
  );

  modport slave (
    input  ra_addr, rb_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output ra_data, rb_data, ra_busy, rb_busy
  );

endinterface : regfile_sb_if
`default_nettype wire

// File: rtl/regfile_entry.sv
`default_nettype none
// ============================================================================
// Module   : regfile_entry
// Brief    : One register-file word with write enable and async clear.
// Revision : 1.0
// ============================================================================
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int ENTRY_W = regfile_pkg::WIDTH
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               we,
  input  wire logic [ENTRY_W-1:0] d,
  output      logic [ENTRY_W-1:0] q
);

  logic [ENTRY_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (we) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : regfile_entry
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : 2R/1W register file with write-first bypass and busy scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH = regfile_pkg::WIDTH,
  parameter int DEPTH = regfile_pkg::DEPTH
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  regfile_sb_if.slave   rf
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] w_entry [DEPTH];
  logic [DEPTH-1:1] w_we;
  logic             w_wr_hit;
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  assign w_wr_hit   = rf.wr_en && (rf.wr_addr != ZERO_REG);
  assign w_entry[0] = '0;

  generate
    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
      assign w_we[i] = w_wr_hit && (rf.wr_addr == c_ADDR_W'(i));

      regfile_entry #(
        .ENTRY_W (WIDTH)
      ) u_entry (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we[i]),
        .d     (rf.wr_data),
        .q     (w_entry[i])
      );
    end
  endgenerate

  // A new producer issued in the same cycle as a writeback supersedes it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_hit) begin
      w_busy_nxt[rf.wr_addr] = 1'b0;
    end
    if (rf.iss_en && (rf.iss_addr != ZERO_REG)) begin
      w_busy_nxt[rf.iss_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign rf.ra_data = (w_wr_hit && (rf.ra_addr == rf.wr_addr)) ? rf.wr_data
                                                               : w_entry[rf.ra_addr];
  assign rf.rb_data = (w_wr_hit && (rf.rb_addr == rf.wr_addr)) ? rf.wr_data
                                                               : w_entry[rf.rb_addr];

  // The writeback in flight resolves the hazard, matching the bypass path.
  assign rf.ra_busy = r_busy[rf.ra_addr] & ~(rf.wr_en & (rf.wr_addr == rf.ra_addr));
  assign rf.rb_busy = r_busy[rf.rb_addr] & ~(rf.wr_en & (rf.wr_addr == rf.rb_addr));

endmodule : regfile_sb
`default_nettype wire
